// File: rtl/gray_bin_pipe.sv
// Two-stage pipelined Gray<->binary converter with a valid/ready stream interface.
// Each word's mode bit picks its direction: 0 = Gray->binary, 1 = binary->Gray.
module gray_bin_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_mode,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q,  s1_data_d;
    logic                 s1_mode_q,  s1_mode_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic                 out_mode_q,  out_mode_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q,  xfer_cnt_d;

    logic             s1_en;
    logic             s2_en;
    logic [WIDTH-1:0] conv_data;

    // NOTE: in_ready depends combinationally on out_ready; upstream must not
    // feed in_ready back into out_ready or a loop forms.
    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;

    // Gray->binary is a running XOR from the MSB down; binary->Gray is b ^ (b >> 1).
    always_comb begin
        logic acc;
        conv_data = '0;
        acc       = 1'b0;
        if (s1_mode_q) begin
            conv_data = s1_data_q ^ (s1_data_q >> 1);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                acc          = acc ^ s1_data_q[i];
                conv_data[i] = acc;
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        xfer_cnt_d  = xfer_cnt_q;

        // Bubbles advance the valid bit only; data registers keep their last value.
        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_mode_d = in_mode;
            end
        end

        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = conv_data;
                out_mode_d = s1_mode_q;
            end
        end

        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: data registers are reset too, so no X can reach out_data after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Bench for gray_bin_pipe: directed 4-bit streams, backpressure, counter wrap,
// mid-flight reset, and a randomized 8-bit run against a scoreboard.
module tb_gray_bin_pipe;

    localparam int W8     = 8;
    localparam int NWORDS = 10000;
    localparam int BUDGET = 60000;

    logic clk;
    logic rst;

    // Two 4-bit instances share stimulus; dut_c has a 4-bit counter for the wrap test.
    logic        v4, m4, ordy4;
    logic [3:0]  d4;
    logic        rdy4, ov4, om4;
    logic [3:0]  od4;
    logic [15:0] cnt4;
    logic        rdyc, ovc, omc;
    logic [3:0]  odc;
    logic [3:0]  cntc;

    logic          v8, m8, ordy8;
    logic [W8-1:0] d8;
    logic          rdy8, ov8, om8;
    logic [W8-1:0] od8;
    logic [15:0]   cnt8;

    gray_bin_pipe #(.WIDTH(4), .CNT_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_mode(m4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_mode(om4),
        .xfer_cnt(cnt4)
    );

    gray_bin_pipe #(.WIDTH(4), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(rdyc), .in_data(d4), .in_mode(m4),
        .out_valid(ovc), .out_ready(ordy4), .out_data(odc), .out_mode(omc),
        .xfer_cnt(cntc)
    );

    gray_bin_pipe #(.WIDTH(W8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_mode(m8),
        .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_mode(om8),
        .xfer_cnt(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Reference: the binary value whose Gray code equals g, found by search.
    function automatic logic [W8-1:0] ref_g2b(input logic [W8-1:0] g);
        for (int v = 0; v < (1 << W8); v++) begin
            if ((v ^ (v >> 1)) == int'(g)) return W8'(v);
        end
        return '0;
    endfunction

    function automatic logic [W8-1:0] ref_b2g(input logic [W8-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                              4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
    logic [3:0] bp_w [3] = '{4'h3, 4'h5, 4'h9};

    logic [W8:0] exp_q [$];
    logic [W8:0] exp_w;
    int          delivered;
    int          sent;
    int          cycles;
    int          k;
    logic        acc8;
    logic        prev_stall;
    logic [W8-1:0] prev_data;
    logic        prev_mode;

    initial begin
        rst = 1'b1;
        v4 = 1'b0; d4 = '0; m4 = 1'b0; ordy4 = 1'b0;
        v8 = 1'b0; d8 = '0; m8 = 1'b0; ordy8 = 1'b0;
        #22 rst = 1'b0;
        to_pos();

        // Reset values
        check("rst_out_valid", ov4, 0);
        check("rst_out_data", od4, 0);
        check("rst_out_mode", om4, 0);
        check("rst_xfer_cnt", cnt4, 0);
        check("rst_in_ready", rdy4, 1);
        check("rst_out_valid8", ov8, 0);
        check("rst_out_data8", od8, 0);

        // Gray 0..15 with mode 0, downstream always ready
        ordy4 = 1'b1;
        for (int c = 0; c < 18; c++) begin
            v4 = (c < 16);
            d4 = 4'(c);
            m4 = 1'b0;
            @(negedge clk);
            if (c == 1) check("g_latency_early", ov4, 0);
            if (c >= 2) begin
                check($sformatf("g_valid%0d", c - 2), ov4, 1);
                check($sformatf("g_data%0d", c - 2), od4, gtab[c - 2]);
                check($sformatf("g_mode%0d", c - 2), om4, 0);
            end
            to_pos();
        end
        v4 = 1'b0;
        check("g_xfer_cnt", cnt4, 16);
        check("wrap_cnt_16", cntc, 0);

        // Round trip, mixed modes back-to-back
        for (int c = 0; c < 4; c++) begin
            v4 = (c < 2);
            d4 = (c == 0) ? 4'b1011 : 4'b1101;
            m4 = (c == 1);
            @(negedge clk);
            if (c == 2) begin
                check("rt0_valid", ov4, 1);
                check("rt0_data", od4, 4'b1101);
                check("rt0_mode", om4, 0);
            end
            if (c == 3) begin
                check("rt1_valid", ov4, 1);
                check("rt1_data", od4, 4'b1011);
                check("rt1_mode", om4, 1);
                check("rt_cnt_17", cnt4, 17);
                check("wrap_cnt_17", cntc, 1);
            end
            to_pos();
        end
        v4 = 1'b0;
        check("rt_cnt_18", cnt4, 18);

        // Backpressure: three words offered while downstream stalls
        ordy4 = 1'b0;
        m4 = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) ordy4 = 1'b1;
            v4 = (k < 3);
            d4 = bp_w[(k < 3) ? k : 0];
            @(negedge clk);
            case (c)
                0, 1: check($sformatf("bp_ready%0d", c), rdy4, 1);
                2, 3: begin
                    check($sformatf("bp_ready%0d", c), rdy4, 0);
                    check($sformatf("bp_hold_valid%0d", c), ov4, 1);
                    check($sformatf("bp_hold_data%0d", c), od4, 4'h2);
                end
                4: begin
                    check("bp_third_after_release", k, 2);
                    check("bp_ready_release", rdy4, 1);
                    check("bp_out0", od4, 4'h2);
                end
                5: check("bp_out1", od4, 4'h7);
                6: begin
                    check("bp_out2", od4, 4'hD);
                    check("bp_out2_mode", om4, 1);
                end
                7: check("bp_drained", ov4, 0);
                default: ;
            endcase
            if (v4 && rdy4) k++;
            to_pos();
        end
        v4 = 1'b0;
        check("bp_cnt", cnt4, 21);

        // Reset while two words are held
        ordy4 = 1'b0;
        m4 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            v4 = 1'b1;
            d4 = 4'(c + 1);
            to_pos();
        end
        v4 = 1'b0;
        @(negedge clk);
        check("mr_full_valid", ov4, 1);
        check("mr_full_ready", rdy4, 0);
        #2 rst = 1'b1;
        #1;
        check("mr_valid_async", ov4, 0);
        check("mr_cnt_clear", cnt4, 0);
        check("mr_cntc_clear", cntc, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ordy4 = 1'b1;
        to_pos();
        check("mr_no_stale", ov4, 0);
        for (int c = 0; c < 4; c++) begin
            v4 = (c == 0);
            d4 = 4'hA;
            m4 = 1'b1;
            @(negedge clk);
            if (c == 1 || c == 3) check($sformatf("mr_valid%0d", c), ov4, 0);
            if (c == 2) begin
                check("mr_valid2", ov4, 1);
                check("mr_data", od4, 4'hF);
                check("mr_mode", om4, 1);
            end
            to_pos();
        end
        v4 = 1'b0;
        check("mr_cnt", cnt4, 1);

        // Randomized 8-bit run against the scoreboard
        delivered  = 0;
        sent       = 0;
        cycles     = 0;
        acc8       = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_mode  = 1'b0;
        while (delivered < NWORDS && cycles < BUDGET) begin
            if (acc8) v8 = 1'b0;
            if (!v8) begin
                d8 = W8'($urandom);
                m8 = $urandom_range(1);
                if (sent < NWORDS && $urandom_range(3) != 0) begin
                    v8 = 1'b1;
                    sent++;
                end
            end
            ordy8 = ($urandom_range(3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                check("rnd_stall_valid", ov8, 1);
                check("rnd_stall_data", od8, prev_data);
                check("rnd_stall_mode", om8, prev_mode);
            end
            if (ov8 && ordy8) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_word", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("rnd_data", od8, exp_w[W8-1:0]);
                    check("rnd_mode", om8, exp_w[W8]);
                end
                delivered++;
            end
            acc8 = v8 && rdy8;
            if (acc8) exp_q.push_back({m8, m8 ? ref_b2g(d8) : ref_g2b(d8)});
            prev_stall = ov8 && !ordy8;
            prev_data  = od8;
            prev_mode  = om8;
            cycles++;
            to_pos();
        end
        v8 = 1'b0;
        ordy8 = 1'b0;
        check("rnd_delivered", delivered, NWORDS);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_xfer_cnt", cnt8, delivered);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
